// File: rtl/img_rsz_pxl_fwd.sv
// img_rsz_pxl_fwd: drains executed blocks in raster order into a one-entry valid/ready pixel stage.
// Optional frame counter enabled by defining IMG_RSZ_FWD_FRAME_CNT_EN.
module img_rsz_pxl_fwd #(
    parameter int RSZ_IMG_WIDTH_SIZE  = 32,
    parameter int RSZ_IMG_HEIGHT_SIZE = 32,
    parameter int RSZ_IMG_WIDTH_IDX_W = $clog2(RSZ_IMG_WIDTH_SIZE),
    parameter int RSZ_IMG_HEIGHT_IDX_W = $clog2(RSZ_IMG_HEIGHT_SIZE),
    parameter int PXL_PRIM_COLOR_NUM  = 3,
    parameter int PXL_PRIM_COLOR_W    = 8
) (
    input  logic                                                     Clk,
    input  logic                                                     ResetN,
    input  logic                                                     FwdClr,
    input  logic [RSZ_IMG_HEIGHT_SIZE-1:0][RSZ_IMG_WIDTH_SIZE-1:0]   BlkIsExec,
    input  logic [PXL_PRIM_COLOR_NUM-1:0][PXL_PRIM_COLOR_W-1:0]      FlushRszPxlData,
    output logic [RSZ_IMG_WIDTH_SIZE-1:0]                            FlushBlkXMsk,
    output logic [RSZ_IMG_HEIGHT_SIZE-1:0]                           FlushBlkYMsk,
    output logic                                                     FlushVld,
    output logic [PXL_PRIM_COLOR_NUM-1:0][PXL_PRIM_COLOR_W-1:0]      RszPxlData,
    output logic [RSZ_IMG_WIDTH_IDX_W-1:0]                           RszPxlX,
    output logic [RSZ_IMG_HEIGHT_IDX_W-1:0]                          RszPxlY,
    output logic                                                     RszPxlLast,
    output logic                                                     RszPxlVld,
    input  logic                                                     RszPxlRdy,
    output logic [15:0]                                              FrameCnt
);
    localparam logic [RSZ_IMG_WIDTH_IDX_W-1:0]  LastU = RSZ_IMG_WIDTH_IDX_W'(RSZ_IMG_WIDTH_SIZE - 1);
    localparam logic [RSZ_IMG_HEIGHT_IDX_W-1:0] LastV = RSZ_IMG_HEIGHT_IDX_W'(RSZ_IMG_HEIGHT_SIZE - 1);

    logic [RSZ_IMG_WIDTH_IDX_W-1:0]  curU;
    logic [RSZ_IMG_HEIGHT_IDX_W-1:0] curV;
    logic free, load, endU, endV;

    assign FlushBlkXMsk = RSZ_IMG_WIDTH_SIZE'(1) << curU;
    assign FlushBlkYMsk = RSZ_IMG_HEIGHT_SIZE'(1) << curV;
    assign free = !RszPxlVld || RszPxlRdy;
    assign load = BlkIsExec[curV][curU] && free && !FwdClr;
    assign FlushVld = load;
    assign endU = curU == LastU;
    assign endV = curV == LastV;

    // The buffer drops the flag at the edge that samples FlushVld, so no double capture is possible.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            curU       <= '0;
            curV       <= '0;
            RszPxlVld  <= 1'b0;
            RszPxlLast <= 1'b0;
            RszPxlData <= '0;
            RszPxlX    <= '0;
            RszPxlY    <= '0;
        end else if (FwdClr) begin
            curU      <= '0;
            curV      <= '0;
            RszPxlVld <= 1'b0;
        end else if (load) begin
            RszPxlData <= FlushRszPxlData;
            RszPxlX    <= curU;
            RszPxlY    <= curV;
            RszPxlLast <= endU && endV;
            RszPxlVld  <= 1'b1;
            curU       <= endU ? '0 : curU + 1'b1;
            curV       <= endU ? (endV ? '0 : curV + 1'b1) : curV;
        end else if (RszPxlRdy) begin
            RszPxlVld <= 1'b0;
        end
    end

`ifdef IMG_RSZ_FWD_FRAME_CNT_EN
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN)
            FrameCnt <= '0;
        else if (RszPxlVld && RszPxlRdy && RszPxlLast)
            FrameCnt <= FrameCnt + 1'b1;
    end
`else
    assign FrameCnt = '0;
`endif
endmodule

// File: tb/tb_img_rsz_pxl_fwd.sv
// tb_img_rsz_pxl_fwd: table-driven bench for img_rsz_pxl_fwd at U=V=4 with a block-buffer flag model.
module tb_img_rsz_pxl_fwd;
    logic               Clk = 1'b0;
    logic               ResetN, FwdClr, RszPxlRdy;
    logic [15:0]        flags;
    logic [3:0][3:0]    BlkIsExec;
    logic [2:0][7:0]    FlushRszPxlData, RszPxlData;
    logic [3:0]         FlushBlkXMsk, FlushBlkYMsk;
    logic               FlushVld, RszPxlLast, RszPxlVld;
    logic [1:0]         RszPxlX, RszPxlY;
    logic [15:0]        FrameCnt;
    int                 mx, my, checks = 0, failures = 0;

    typedef struct {
        int setm; bit rdy; bit clr; bit rst;
        bit efv; bit evld; int ex; int ey; bit elast; int ecur; int efc;
    } vec_t;
    vec_t vecs[$];

    img_rsz_pxl_fwd #(.RSZ_IMG_WIDTH_SIZE(4), .RSZ_IMG_HEIGHT_SIZE(4)) dut (
        .Clk(Clk), .ResetN(ResetN), .FwdClr(FwdClr), .BlkIsExec(BlkIsExec),
        .FlushRszPxlData(FlushRszPxlData), .FlushBlkXMsk(FlushBlkXMsk), .FlushBlkYMsk(FlushBlkYMsk),
        .FlushVld(FlushVld), .RszPxlData(RszPxlData), .RszPxlX(RszPxlX), .RszPxlY(RszPxlY),
        .RszPxlLast(RszPxlLast), .RszPxlVld(RszPxlVld), .RszPxlRdy(RszPxlRdy), .FrameCnt(FrameCnt)
    );

    always #5 Clk = ~Clk;

    function automatic logic [23:0] pix(input int i);
        return {8'(8'hA5 ^ i), 8'(i + 1), 8'(8 * i)};
    endfunction

    function automatic int fc(input int n);
`ifdef IMG_RSZ_FWD_FRAME_CNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    // Buffer side: the pixel of the block addressed by the masks.
    assign BlkIsExec = flags;
    always_comb begin
        mx = 0;
        my = 0;
        for (int i = 0; i < 4; i++) begin
            if (FlushBlkXMsk[i]) mx = i;
            if (FlushBlkYMsk[i]) my = i;
        end
        FlushRszPxlData = pix(my * 4 + mx);
    end

    task automatic chk(input string name, input int row, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, got, exp);
        end
    endtask

    task automatic add(input int setm, input bit rdy, input bit clr, input bit rst, input bit efv,
                       input bit evld, input int ex, input int ey, input bit elast, input int ecur, input int efc);
        vec_t v;
        v = '{setm, rdy, clr, rst, efv, evld, ex, ey, elast, ecur, efc};
        vecs.push_back(v);
    endtask

    task automatic add_frames(input int nf, input bit rst);
        for (int g = 0; g < 16 * nf; g++) begin
            int p;
            p = (g + 16 * nf - 1) % (16 * nf);
            add(1 << (g % 16), 1, 0, (g == 0) ? rst : 1'b0, 1, g > 0, p % 4, (p % 16) / 4,
                (p % 16) == 15, g % 16, (g == 17) ? fc(1) : -1);
        end
        add(0, 1, 0, 0, 0, 1, 3, 3, 1, 0, -1);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, fc(nf));
    endtask

    task automatic tick();
        bit fv;
        int cx, cy;
        fv = FlushVld;
        cx = mx;
        cy = my;
        @(posedge Clk);
        #1;
        if (fv) flags[cy * 4 + cx] = 1'b0;
    endtask

    initial begin
        ResetN = 1'b0;
        FwdClr = 1'b0;
        RszPxlRdy = 1'b1;
        flags = '0;
        // reset, then one full-rate frame
        add(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, fc(0));
        add_frames(1, 0);
        // backpressure: (0,0) held five cycles, then (1,0) loads with no bubble
        add(3, 0, 0, 0, 1, 0, 0, 0, 0, 0, -1);
        for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, -1);
        add(0, 1, 0, 0, 1, 1, 0, 0, 0, 1, -1);
        add(0, 1, 0, 0, 0, 1, 1, 0, 0, 2, -1);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 2, -1);
        // out of order: (2,1) ignored until the cursor gets there
        add(0, 1, 1, 0, 0, 0, 0, 0, 0, 2, -1);
        add(1 << 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, -1);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, -1);
        add(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, -1);
        add(0, 1, 0, 0, 0, 1, 0, 0, 0, 1, -1);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, -1);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, -1);
        // soft clear colliding with a load of (3,0)
        add(2, 1, 0, 0, 1, 0, 0, 0, 0, 1, -1);
        add(4, 1, 0, 0, 1, 1, 1, 0, 0, 2, -1);
        add(8, 1, 1, 0, 0, 1, 2, 0, 0, 3, -1);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, fc(1));
        // two back-to-back frames after reset
        add_frames(2, 1);

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            if (v.rst) begin
                ResetN = 1'b0;
                flags = '0;
                #2;
                @(negedge Clk);
                ResetN = 1'b1;
                #1;
                chk("rst_data", i, RszPxlData, 0);
                chk("rst_xy", i, {RszPxlX, RszPxlY}, 0);
                chk("rst_last", i, RszPxlLast, 0);
                chk("rst_fcnt", i, FrameCnt, 0);
            end
            flags = flags | 16'(v.setm);
            RszPxlRdy = v.rdy;
            FwdClr = v.clr;
            #1;
            chk("flushvld", i, FlushVld, v.efv);
            chk("vld", i, RszPxlVld, v.evld);
            chk("xmsk", i, FlushBlkXMsk, 1 << (v.ecur % 4));
            chk("ymsk", i, FlushBlkYMsk, 1 << (v.ecur / 4));
            if (v.evld) begin
                chk("x", i, RszPxlX, v.ex);
                chk("y", i, RszPxlY, v.ey);
                chk("last", i, RszPxlLast, v.elast);
                chk("data", i, RszPxlData, pix(v.ey * 4 + v.ex));
            end
            if (v.efc >= 0) chk("fcnt", i, FrameCnt, v.efc);
            tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
